// File: rtl/lzc_pkg.sv
// Shared constants and helpers for the registered leading-zero counter.
package lzc_pkg;

    localparam int LZC_M = 12;
    localparam int LZC_N = 12;
    localparam int GW    = 4;

    // Count width able to hold every value 0..w without wrap.
    function automatic int lzc_cw(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/lzc_nib.sv
// 4-bit priority encoder: leading-zero count of one group plus an all-zero flag.
module lzc_nib (
    input  logic [3:0] d_i,
    output logic [1:0] cnt_o,
    output logic       zero_o
);

    always_comb begin
        cnt_o  = 2'd3;
        zero_o = 1'b0;
        casez (d_i)
            4'b1???: cnt_o = 2'd0;
            4'b01??: cnt_o = 2'd1;
            4'b001?: cnt_o = 2'd2;
            4'b0001: cnt_o = 2'd3;
            default: zero_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/lzc_reg.sv
// Registered leading-zero counter for a raw QM.N word (MSB = bit W-1).
// Define LZC_PIPE2_EN to register the per-group flags/counts first (latency 2).
module lzc_reg
    import lzc_pkg::*;
#(
    parameter  int M  = LZC_M,
    parameter  int N  = LZC_N,
    localparam int W  = M + N,
    localparam int CW = lzc_cw(W)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_valid,
    input  logic [W-1:0]  i_data,
    output logic          o_valid,
    output logic [CW-1:0] o_lzc,
    output logic          o_zero
);

    localparam int NG = (W + GW - 1) / GW;
    localparam int PW = NG * GW;

    // LSB-side zero padding can never hold the first set bit, so the count stays <= W.
    logic [PW-1:0]         pad_w;
    logic [NG-1:0]         nib_zero;
    logic [NG-1:0][1:0]    nib_cnt;

    assign pad_w = PW'(i_data) << (PW - W);

    for (genvar g = 0; g < NG; g++) begin : g_nib
        lzc_nib u_nib (
            .d_i    (pad_w[PW-1-GW*g -: GW]),
            .cnt_o  (nib_cnt[g]),
            .zero_o (nib_zero[g])
        );
    end

    logic               sel_v;
    logic [NG-1:0]      sel_zero;
    logic [NG-1:0][1:0] sel_cnt;

`ifdef LZC_PIPE2_EN
    logic               v1_q;
    logic [NG-1:0]      grp_zero_q;
    logic [NG-1:0][1:0] grp_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_q       <= 1'b0;
            grp_zero_q <= '0;
            grp_cnt_q  <= '0;
        end else begin
            v1_q <= i_valid;
            if (i_valid) begin
                grp_zero_q <= nib_zero;
                grp_cnt_q  <= nib_cnt;
            end
        end
    end

    assign sel_v    = v1_q;
    assign sel_zero = grp_zero_q;
    assign sel_cnt  = grp_cnt_q;
`else
    assign sel_v    = i_valid;
    assign sel_zero = nib_zero;
    assign sel_cnt  = nib_cnt;
`endif

    logic [CW-1:0] lzc_d;
    logic          zero_d;

    // Scan from the LSB group upward so the most-significant non-zero group wins.
    always_comb begin
        lzc_d  = CW'(W);
        zero_d = 1'b1;
        for (int unsigned i = 0; i < NG; i++) begin
            if (!sel_zero[NG-1-i]) begin
                lzc_d  = CW'(GW * (NG - 1 - i)) + CW'(sel_cnt[NG-1-i]);
                zero_d = 1'b0;
            end
        end
    end

    logic          valid_q;
    logic [CW-1:0] lzc_q;
    logic          zero_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            lzc_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            valid_q <= sel_v;
            if (sel_v) begin
                lzc_q  <= lzc_d;
                zero_q <= zero_d;
            end
        end
    end

    assign o_valid = valid_q;
    assign o_lzc   = lzc_q;
    assign o_zero  = zero_q;

endmodule

// File: tb/tb_lzc_reg.sv
// Directed self-checking bench for lzc_reg (latency follows LZC_PIPE2_EN).
module tb_lzc_reg;

`ifdef LZC_PIPE2_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk     = 1'b0;
    logic        reset   = 1'b0;
    logic        i_valid = 1'b0;
    logic [23:0] i_data  = '0;
    logic        o_valid;
    logic [4:0]  o_lzc;
    logic        o_zero;

    int total = 0;
    int bad   = 0;

    lzc_reg #(.M(12), .N(12)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_valid (i_valid),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_lzc   (o_lzc),
        .o_zero  (o_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, req);
        end
    endtask

    // Present one word for one cycle, then check the result at its latency.
    task automatic run_one(input logic [23:0] d, input int el, input logic ez, input string tag);
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = d;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (LAT - 1) begin
            @(posedge clk);
            #1;
        end
        chk({tag, "_valid"}, 32'(o_valid), 32'd1);
        chk({tag, "_lzc"},   32'(o_lzc),   32'(el));
        chk({tag, "_zero"},  32'(o_zero),  32'(ez));
    endtask

    logic [23:0] dir_d [5]   = '{24'h800000, 24'h7FFFFF, 24'h001000, 24'h000800, 24'h000001};
    int          dir_e [5]   = '{0, 1, 11, 12, 23};
    logic [23:0] str_d [3]   = '{24'h000010, 24'h010000, 24'hFFFFFF};
    int          str_e [3]   = '{19, 7, 0};

    initial begin
        // Reset asserted asynchronously with a live input word.
        #2;
        reset   = 1'b1;
        i_valid = 1'b1;
        i_data  = 24'h000001;
        #1;
        chk("rst_async_valid", 32'(o_valid), 32'd0);
        chk("rst_async_lzc",   32'(o_lzc),   32'd0);
        chk("rst_async_zero",  32'(o_zero),  32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_valid", 32'(o_valid), 32'd0);
        chk("rst_hold_lzc",   32'(o_lzc),   32'd0);
        chk("rst_hold_zero",  32'(o_zero),  32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (LAT) @(posedge clk);
        #1;
        chk("rst_rel_valid", 32'(o_valid), 32'd1);
        chk("rst_rel_lzc",   32'(o_lzc),   32'd23);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 5; i++)
            run_one(dir_d[i], dir_e[i], 1'b0, $sformatf("dir%0d", i));

        // Gap after the last directed word: valid drops, count holds 23.
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("gap_valid", 32'(o_valid), 32'd0);
            chk("gap_lzc",   32'(o_lzc),   32'd23);
        end

        run_one(24'h000000, 24, 1'b1, "allzero");
        run_one(24'h400000, 1,  1'b0, "after_zero");

        // Back-to-back stream.
        for (int c = 0; c < 3 + LAT + 1; c++) begin
            @(negedge clk);
            if (c < 3) begin
                i_valid = 1'b1;
                i_data  = str_d[c];
            end else begin
                i_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (c - (LAT - 1) >= 0 && c - (LAT - 1) < 3) begin
                chk($sformatf("stream%0d_valid", c - (LAT - 1)), 32'(o_valid), 32'd1);
                chk($sformatf("stream%0d_lzc", c - (LAT - 1)),   32'(o_lzc),   32'(str_e[c - (LAT - 1)]));
            end
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("stream_gap_valid", 32'(o_valid), 32'd0);
            chk("stream_gap_lzc",   32'(o_lzc),   32'd0);
            chk("stream_gap_zero",  32'(o_zero),  32'd0);
        end

        // Single-bit sweep with random bits below the leading one.
        for (int k = 0; k < 24; k++) begin
            logic [23:0] one;
            logic [23:0] d;
            one = 24'd1 << k;
            d   = one | (24'($urandom) & (one - 24'd1));
            run_one(d, 23 - k, 1'b0, $sformatf("sweep%0d", k));
        end

        // Reset asserted mid-stream between clock edges, then resumed.
        run_one(24'h000001, 23, 1'b0, "pre_rst");
        @(negedge clk);
        i_valid = 1'b1;
        i_data  = 24'h000100;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", 32'(o_valid), 32'd0);
        chk("rst_mid_lzc",   32'(o_lzc),   32'd0);
        @(negedge clk);
        reset   = 1'b0;
        i_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_idle_valid", 32'(o_valid), 32'd0);
        run_one(24'h010000, 7, 1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
